// File: rtl/isa.sv
// -----------------------------------------------------------------------------
// isa -- shared machine-level types.
//   register_length : width of one core register (bits)
//   value_t         : one register value
// -----------------------------------------------------------------------------
package isa;

    localparam int unsigned register_length = 8;

    typedef logic [register_length-1:0] value_t;

endpackage : isa

// File: rtl/scanout_pkg.sv
// -----------------------------------------------------------------------------
// scanout_pkg -- types and constants shared by the video scanout blocks.
//   state_t     : scanout controller states
//   FRAME_CNT_W : width of the completed-frame counter
//   clog2_min1  : ceil(log2(n)) clamped to at least 1 bit
// -----------------------------------------------------------------------------
package scanout_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam int unsigned FRAME_CNT_W = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : scanout_pkg

// File: rtl/scanout_raster_counter.sv
// -----------------------------------------------------------------------------
// scanout_raster_counter -- x/y raster position with row/frame wrap and the
// frame-position decode.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : restart at x=y=0 (takes priority over i_advance)
//   i_advance   : step to the next pixel in row-major order
//   o_x, o_y    : current position
//   o_sof       : position is (0,0)
//   o_eol       : position is the last column
//   o_eof       : position is the last column of the last row
// -----------------------------------------------------------------------------
module scanout_raster_counter
    import scanout_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8,
    parameter int unsigned XW     = clog2_min1(WIDTH),
    parameter int unsigned YW     = clog2_min1(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_sof,
    output logic          o_eol,
    output logic          o_eof
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_last) begin
                r_x <= '0;
                // y also wraps so an abandoned-capture end of frame parks at (0,0)
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x   = r_x;
    assign o_y   = r_y;
    assign o_sof = (r_x == '0) && (r_y == '0);
    assign o_eol = w_x_last;
    assign o_eof = w_x_last && w_y_last;

endmodule : scanout_raster_counter

// File: rtl/video_scanout.sv
// -----------------------------------------------------------------------------
// video_scanout -- snapshots a WIDTH x HEIGHT grid of per-core register values
// and streams it out row-major over a valid/ready pixel interface.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   video_in      : grid values, pixel index y*WIDTH+x, register_length bits each
//   capture_req   : request a snapshot (honoured in IDLE or on the eof transfer)
//   capture_ack   : one-cycle pulse in the cycle after the snapshot edge
//   busy          : frame streaming
//   pix_valid     : pixel valid
//   pix_ready     : consumer accepts the pixel
//   pix_data      : pixel value
//   pix_sof/eol/eof : first pixel of frame / last of row / last of frame
//   frame_count   : completed frames (wraps)
//
// Build option: define VIDEO_SCANOUT_COORD_EN to add pix_x / pix_y outputs
// carrying the current raster position (0 when not streaming).
// -----------------------------------------------------------------------------
module video_scanout
    import isa::*;
    import scanout_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [WIDTH*HEIGHT*register_length-1:0] video_in,
    input  logic                                    capture_req,
    output logic                                    capture_ack,
    output logic                                    busy,
    output logic                                    pix_valid,
    input  logic                                    pix_ready,
    output value_t                                  pix_data,
    output logic                                    pix_sof,
    output logic                                    pix_eol,
    output logic                                    pix_eof,
    output logic [FRAME_CNT_W-1:0]                  frame_count
`ifdef VIDEO_SCANOUT_COORD_EN
    ,
    output logic [clog2_min1(WIDTH)-1:0]            pix_x,
    output logic [clog2_min1(HEIGHT)-1:0]           pix_y
`endif
);

    localparam int unsigned VW   = register_length;
    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned XW   = clog2_min1(WIDTH);
    localparam int unsigned YW   = clog2_min1(HEIGHT);
    localparam int unsigned BW   = clog2_min1(NPIX * VW);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NPIX*VW-1:0]       r_buf;
    logic                     r_ack;
    logic [FRAME_CNT_W-1:0]   r_frame_count;

    logic                     w_capture;
    logic                     w_advance;
    logic                     w_valid;
    logic [XW-1:0]            w_x;
    logic [YW-1:0]            w_y;
    logic                     w_sof;
    logic                     w_eol;
    logic                     w_eof;
    logic [BW-1:0]            w_base;

    // ------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------
    scanout_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_raster (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_capture),
        .i_advance (w_advance),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_sof     (w_sof),
        .o_eol     (w_eol),
        .o_eof     (w_eof)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (capture_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pix_ready) begin
                    w_advance = 1'b1;
                    if (w_eof) begin
                        // A request on the eof transfer chains the next frame
                        // with no idle cycle; otherwise it is ignored mid-frame.
                        if (capture_req) begin
                            w_capture = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow buffer, ack pulse, frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf         <= '0;
            r_ack         <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_ack <= w_capture;
            if (w_capture) begin
                r_buf <= video_in;
            end
            if (w_advance && w_eof) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_valid = (r_state == ST_STREAM);
    assign w_base  = BW'((32'(w_y) * WIDTH + 32'(w_x)) * VW);

    assign capture_ack = r_ack;
    assign busy        = w_valid;
    assign pix_valid   = w_valid;
    assign pix_data    = w_valid ? r_buf[w_base +: VW] : '0;
    assign pix_sof     = w_valid && w_sof;
    assign pix_eol     = w_valid && w_eol;
    assign pix_eof     = w_valid && w_eof;
    assign frame_count = r_frame_count;

`ifdef VIDEO_SCANOUT_COORD_EN
    assign pix_x = w_valid ? w_x : '0;
    assign pix_y = w_valid ? w_y : '0;
`endif

endmodule : video_scanout

// File: tb/tb_video_scanout.sv
module tb_video_scanout;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int VW = 8;

    // ---------------- 2x2 instance ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*VW-1:0] video_in = '0;
    logic            capture_req = 1'b0;
    logic            pix_ready = 1'b0;
    logic            capture_ack, busy, pix_valid, pix_sof, pix_eol, pix_eof;
    logic [VW-1:0]   pix_data;
    logic [15:0]     frame_count;
`ifdef VIDEO_SCANOUT_COORD_EN
    logic [0:0]      pix_x, pix_y;
`endif

    always #5 clk = ~clk;

    video_scanout #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .video_in    (video_in),
        .capture_req (capture_req),
        .capture_ack (capture_ack),
        .busy        (busy),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .frame_count (frame_count)
`ifdef VIDEO_SCANOUT_COORD_EN
        ,
        .pix_x       (pix_x),
        .pix_y       (pix_y)
`endif
    );

    // ---------------- 1x1 instance (fast clock) ----------------
    logic            clk1 = 1'b0;
    logic            rst1_n = 1'b0;
    logic [VW-1:0]   vin1 = '0;
    logic            cap1 = 1'b0;
    logic            rdy1 = 1'b0;
    logic            ack1, busy1, valid1, sof1, eol1, eof1;
    logic [VW-1:0]   data1;
    logic [15:0]     fc1;
`ifdef VIDEO_SCANOUT_COORD_EN
    logic [0:0]      px1, py1;
`endif
    bit              done1 = 1'b0;

    always #1 clk1 = ~clk1;

    video_scanout #(
        .WIDTH  (1),
        .HEIGHT (1)
    ) u_dut1 (
        .clk         (clk1),
        .rst_n       (rst1_n),
        .video_in    (vin1),
        .capture_req (cap1),
        .capture_ack (ack1),
        .busy        (busy1),
        .pix_valid   (valid1),
        .pix_ready   (rdy1),
        .pix_data    (data1),
        .pix_sof     (sof1),
        .pix_eol     (eol1),
        .pix_eof     (eof1),
        .frame_count (fc1)
`ifdef VIDEO_SCANOUT_COORD_EN
        ,
        .pix_x       (px1),
        .pix_y       (py1)
`endif
    );

    // ---------------- checking ----------------
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame = list of N pixel values taken at the capture edge; the model walks
    // a pixel index k through it, deriving flags from k arithmetically.
    logic [VW-1:0] m_buf [N];
    bit            m_active = 1'b0;
    int            m_k = 0;
    int unsigned   m_fc = 0;
    bit            m_ack = 1'b0;

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_fc     = 0;
        m_ack    = 1'b0;
    endtask

    task automatic model_snapshot();
        for (int i = 0; i < N; i++) m_buf[i] = video_in[i*VW +: VW];
    endtask

    task automatic model_edge(input bit cap, input bit rdy);
        bit ack_n;
        ack_n = 1'b0;
        if (!m_active) begin
            if (cap) begin
                model_snapshot();
                m_k      = 0;
                m_active = 1'b1;
                ack_n    = 1'b1;
            end
        end else if (rdy) begin
            if (m_k == N - 1) begin
                m_fc = (m_fc + 1) % 65536;
                if (cap) begin
                    model_snapshot();
                    m_k   = 0;
                    ack_n = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_k++;
            end
        end
        m_ack = ack_n;
    endtask

    task automatic check_outputs();
        check("valid", 32'(pix_valid), 32'(m_active));
        check("busy", 32'(busy), 32'(m_active));
        check("ack", 32'(capture_ack), 32'(m_ack));
        check("frame_count", 32'(frame_count), m_fc);
        if (m_active) begin
            check("data", 32'(pix_data), 32'(m_buf[m_k]));
            check("sof", 32'(pix_sof), 32'(m_k == 0));
            check("eol", 32'(pix_eol), 32'((m_k % W) == W - 1));
            check("eof", 32'(pix_eof), 32'(m_k == N - 1));
`ifdef VIDEO_SCANOUT_COORD_EN
            check("pix_x", 32'(pix_x), 32'(m_k % W));
            check("pix_y", 32'(pix_y), 32'(m_k / W));
`endif
        end else begin
            check("idle_flags", {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
`ifdef VIDEO_SCANOUT_COORD_EN
            check("idle_xy", {30'd0, pix_x, pix_y}, 32'd0);
`endif
        end
    endtask

    // Called at a negedge: check, drive inputs for the coming edge, advance model.
    task automatic step(input bit cap, input bit rdy);
        check_outputs();
        capture_req = cap;
        pix_ready   = rdy;
        model_edge(cap, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [N*VW-1:0] grid(input logic [7:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    // ---------------- main sequence (2x2) ----------------
    initial begin
        model_reset();
        #3;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_ack", 32'(capture_ack), 32'd0);
        check("rst_fc", 32'(frame_count), 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1);

        // basic frame
        video_in = grid(8'd1, 8'd2, 8'd3, 8'd4);
        step(1, 1);
        check("basic_first", 32'(pix_data), 32'd1);
        repeat (4) step(0, 1);
        check("basic_fc", 32'(frame_count), 32'd1);
        check("basic_busy", 32'(busy), 32'd0);
        step(0, 1);

        // backpressure on pixel 2
        step(1, 1);
        step(0, 1);
        repeat (3) step(0, 0);
        check("bp_hold", 32'(pix_data), 32'd2);
        repeat (3) step(0, 1);

        // snapshot isolation with mid-frame capture requests
        video_in = grid(8'd1, 8'd2, 8'd3, 8'd4);
        step(1, 1);
        video_in = grid(8'd9, 8'd9, 8'd9, 8'd9);
        step(1, 1);
        check("iso_noack", 32'(capture_ack), 32'd0);
        step(1, 1);
        check("iso_data", 32'(pix_data), 32'd3);
        step(0, 1);
        step(0, 1);

        // back-to-back frames
        video_in = grid(8'd1, 8'd2, 8'd3, 8'd4);
        step(1, 1);
        repeat (3) step(0, 1);
        video_in = grid(8'd5, 8'd6, 8'd7, 8'd8);
        step(1, 1);
        check("b2b_valid", 32'(pix_valid), 32'd1);
        check("b2b_sof", 32'(pix_sof), 32'd1);
        check("b2b_data", 32'(pix_data), 32'd5);
        repeat (5) step(0, 1);

        // reset mid-frame after pixel 2
        video_in = grid(8'd1, 8'd2, 8'd3, 8'd4);
        step(1, 1);
        step(0, 1);
        check("pre_rst_data", 32'(pix_data), 32'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_valid", 32'(pix_valid), 32'd0);
        check("midrst_eof", 32'(pix_eof), 32'd0);
        check("midrst_fc", 32'(frame_count), 32'd0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        step(1, 1);
        check("restart_sof", 32'(pix_sof), 32'd1);
        check("restart_data", 32'(pix_data), 32'd1);
        repeat (4) step(0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            video_in = $urandom;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (8) step(0, 1);

        for (int i = 0; i < 200000 && !done1; i++) @(posedge clk1);
        check("1x1_done", 32'(done1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // ---------------- 1x1 grid and frame counter wrap ----------------
    initial begin
        rdy1 = 1'b1;
        vin1 = 8'd7;
        repeat (2) @(negedge clk1);
        check("1x1_rst_fc", 32'(fc1), 32'd0);
        check("1x1_rst_valid", 32'(valid1), 32'd0);
        rst1_n = 1'b1;
        cap1   = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        check("1x1_data", 32'(data1), 32'd7);
        check("1x1_flags", {29'd0, sof1, eol1, eof1}, 32'd7);
        check("1x1_ack", 32'(ack1), 32'd1);
        check("1x1_fc0", 32'(fc1), 32'd0);
        // capture held: every edge completes a frame and chains the next
        repeat (65535) @(posedge clk1);
        @(negedge clk1);
        check("1x1_fc_max", 32'(fc1), 32'hFFFF);
        check("1x1_busy", 32'(busy1), 32'd1);
        @(posedge clk1);
        @(negedge clk1);
        check("1x1_fc_wrap", 32'(fc1), 32'd0);
        cap1 = 1'b0;
        @(posedge clk1);
        @(negedge clk1);
        check("1x1_idle", 32'(valid1), 32'd0);
        check("1x1_fc1", 32'(fc1), 32'd1);
        done1 = 1'b1;
    end

endmodule : tb_video_scanout

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 SHALL have parameter WIDTH, default 8: grid columns (X extent), minimum 1.
REQ-002 SHALL have parameter HEIGHT, default 8: grid rows (Y extent), minimum 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port video_in, input, WIDTH*HEIGHT*VW: per-core video register values, row-major; index = y*WIDTH+x; VW = isa register_length.
REQ-006 SHALL have port capture_req, input, 1: request a snapshot of video_in.
REQ-007 SHALL have port capture_ack, output, 1: one-cycle pulse marking the cycle the snapshot was taken.
REQ-008 SHALL have port busy, output, 1: high while a frame is streaming.
REQ-009 SHALL have port pix_valid, output, 1: pixel valid.
REQ-010 SHALL have port pix_ready, input, 1: consumer accepts the pixel.
REQ-011 SHALL have port pix_data, output, VW: pixel value (isa value_t).
REQ-012 SHALL have ports pix_sof, pix_eol and pix_eof, outputs, 1 each: first pixel of frame, last pixel of row, last pixel of frame.
REQ-013 SHALL have port frame_count, output, 16: number of completed frames.

Function
REQ-014 SHALL implement the states IDLE and STREAM.
REQ-015 In IDLE, when capture_req=1, the block SHALL, at that edge, latch all of video_in into a shadow buffer, clear x and y to 0, pulse capture_ack for the following cycle, and enter STREAM.
REQ-016 In STREAM, pix_valid SHALL be 1, pix_data SHALL equal buffer[y*WIDTH+x], and busy SHALL be 1.
REQ-017 A transfer SHALL occur when pix_valid=1 and pix_ready=1 on the same cycle; on a transfer, x increments; when x=WIDTH-1, x wraps to 0 and y increments.
REQ-018 While pix_ready=0, pix_data, the flags, x and y SHALL hold stable.
REQ-019 The flags SHALL be: pix_sof = (x=0 and y=0); pix_eol = (x=WIDTH-1); pix_eof = (x=WIDTH-1 and y=HEIGHT-1); all flags are qualified by pix_valid and are 0 in IDLE.
REQ-020 On the eof transfer, frame_count SHALL increment (wrapping 0xFFFF to 0x0000) and the state SHALL return to IDLE.
REQ-021 If capture_req=1 on the eof-transfer cycle, the block SHALL re-snapshot and stay in STREAM with x=y=0, giving back-to-back frames with no bubble.
REQ-022 In any other STREAM cycle, capture_req SHALL be ignored: no ack, and the buffer is unchanged.
REQ-023 Changes on video_in after the snapshot SHALL NOT affect the frame being streamed.
REQ-024 For WIDTH=HEIGHT=1, a single pixel SHALL carry sof, eol and eof together.
REQ-025 Latency SHALL be: first pix_valid one cycle after the capture edge; one pixel per cycle under continuous pix_ready.

Reset
REQ-026 While rst_n=0 (asynchronous), the block SHALL force: state=IDLE, x=y=0, buffer all zero, frame_count=0, and capture_ack, busy, pix_valid and the flags all 0; pix_data SHALL be 0.
REQ-027 A reset asserted mid-frame SHALL abandon the frame; no eof is emitted and frame_count is not incremented.

Configuration
REQ-028 With macro VIDEO_SCANOUT_COORD_EN defined, the block SHALL add output ports pix_x ($clog2(WIDTH) bits, minimum 1) and pix_y ($clog2(HEIGHT) bits, minimum 1) carrying the current x and y; these are 0 in IDLE and under reset.
REQ-029 Without VIDEO_SCANOUT_COORD_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 value_t and register_length SHALL come from the isa package.
REQ-031 The state enum and the frame_count width constant SHALL live in a new shared package, scanout_pkg.
REQ-032 The x/y raster counter, including its wrap logic and the sof/eol/eof decode, SHALL be a sub-module named scanout_raster_counter.

Verification
REQ-033 Basic frame: WIDTH=2, HEIGHT=2, video_in={1,2,3,4}, capture_req pulse, pix_ready=1 -> pix_data 1,2,3,4 on consecutive cycles; sof on 1, eol on 2 and 4, eof on 4; then frame_count=1 and busy=0.
REQ-034 Backpressure: pix_ready=0 for 3 cycles while pixel 2 is presented -> pix_data stays 2 and flags are stable; the stream resumes with 3, 4.
REQ-035 Snapshot isolation: after capture, change video_in to {9,9,9,9} and pulse capture_req mid-frame -> output stays 1,2,3,4, and no capture_ack occurs.
REQ-036 Back-to-back: capture_req=1 on the eof-transfer cycle -> the next cycle shows sof with new data, no idle bubble, and frame_count=1.
REQ-037 Reset mid-frame: drop rst_n after pixel 2 -> pix_valid=0 immediately, frame_count=0, state IDLE; a new capture restarts at x=y=0.
REQ-038 Degenerate 1x1 grid with video_in=7 -> a single pixel 7 with sof, eol and eof all 1; frame_count wraps from 0xFFFF to 0 after a preloaded count of 0xFFFF.
